// File: rtl/temp_level_pkg.sv
// Shared types and constants for the temperature-to-level block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package temp_level_pkg;

    localparam int CODE_W = 12;
    localparam logic [6:0] DRP_TEMP_ADDR = 7'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_ACC,
        ST_UPDATE
    } state_t;

endpackage

// File: rtl/temp_level_if.sv
// XADC DRP read port plus the level/status outputs toward the PWM stage.
// Latency: n/a (wiring only).
// Backpressure: none; DRP completion is signalled by i_drdy.
interface temp_level_if;
    logic        i_eoc;
    logic        o_den;
    logic [6:0]  o_daddr;
    logic        o_dwe;
    logic        i_drdy;
    logic [15:0] i_do;
    logic [3:0]  o_lvl;
    logic        o_valid;
    logic        o_timeout;

    modport master (
        input  i_eoc, i_drdy, i_do,
        output o_den, o_daddr, o_dwe, o_lvl, o_valid, o_timeout
    );

    modport slave (
        output i_eoc, i_drdy, i_do,
        input  o_den, o_daddr, o_dwe, o_lvl, o_valid, o_timeout
    );
endinterface

// File: rtl/temp_lvl_map.sv
// Maps a 12-bit temperature code to a 4-bit level, clamped at 15.
// Latency: combinational.
// Backpressure: none.
module temp_lvl_map
    import temp_level_pkg::*;
#(
    parameter logic [CODE_W-1:0] T_MIN_CODE = 12'h977,
    parameter int                STEP_SHIFT = 4
) (
    input  logic [CODE_W-1:0] code,
    output logic [3:0]        lvl
);

    logic [CODE_W-1:0] diff;
    logic [CODE_W-1:0] steps;

    always_comb begin
        // Codes at or below the floor all map to level 0.
        diff  = (code > T_MIN_CODE) ? (code - T_MIN_CODE) : '0;
        steps = diff >> STEP_SHIFT;
        lvl   = (steps > CODE_W'(15)) ? 4'd15 : steps[3:0];
    end

endmodule

// File: rtl/temp_level.sv
// Reads the XADC temperature over DRP on each EOC, averages 2^SAMPLE_LOG2 samples, updates a hysteretic level.
// Latency: o_valid/o_lvl appear the cycle after UPDATE, 3 cycles after the batch-completing i_drdy.
// Backpressure: one read in flight; extra EOCs collapse into a single pending request; missing i_drdy times out.
module temp_level
    import temp_level_pkg::*;
#(
    parameter int                SAMPLE_LOG2 = 3,
    parameter logic [CODE_W-1:0] T_MIN_CODE  = 12'h977,
    parameter int                STEP_SHIFT  = 4,
    parameter int                HYST        = 4,
    parameter int                TIMEOUT     = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    temp_level_if.master bus
);

    localparam int ACC_W  = CODE_W + SAMPLE_LOG2;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    state_t                  state;
    logic                    pending;
    logic [WCNT_W-1:0]       wait_cnt;
    logic [CODE_W-1:0]       sample;
    logic [ACC_W-1:0]        acc;
    logic [SAMPLE_LOG2-1:0]  samp_cnt;
    logic                    den_q;
    logic                    valid_q;
    logic                    timeout_q;
    logic [3:0]              lvl_q;

    logic [ACC_W-1:0]        avg_wide;
    logic [CODE_W-1:0]       avg;
    logic [CODE_W:0]         avg_hyst_sum;
    logic [CODE_W-1:0]       avg_hyst;
    logic [3:0]              raw_up;
    logic [3:0]              raw_dn;

    always_comb begin
        avg_wide     = acc >> SAMPLE_LOG2;
        avg          = avg_wide[CODE_W-1:0];
        avg_hyst_sum = {1'b0, avg} + (CODE_W+1)'(HYST);
        avg_hyst     = avg_hyst_sum[CODE_W] ? {CODE_W{1'b1}} : avg_hyst_sum[CODE_W-1:0];
    end

    // Rising uses the plain average; falling is judged HYST codes higher so small dips don't toggle the level.
    temp_lvl_map #(.T_MIN_CODE(T_MIN_CODE), .STEP_SHIFT(STEP_SHIFT)) u_map_up (
        .code (avg),
        .lvl  (raw_up)
    );

    temp_lvl_map #(.T_MIN_CODE(T_MIN_CODE), .STEP_SHIFT(STEP_SHIFT)) u_map_dn (
        .code (avg_hyst),
        .lvl  (raw_dn)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pending   <= 1'b0;
            wait_cnt  <= '0;
            sample    <= '0;
            acc       <= '0;
            samp_cnt  <= '0;
            den_q     <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            lvl_q     <= 4'd0;
        end else begin
            den_q     <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.i_eoc || pending) begin
                        den_q <= 1'b1;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    pending  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.i_drdy) begin
                        sample <= bus.i_do[15:4];
                        state  <= ST_ACC;
                    end else if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_ACC: begin
                    acc      <= acc + ACC_W'(sample);
                    samp_cnt <= samp_cnt + 1'b1;
                    state    <= (samp_cnt == '1) ? ST_UPDATE : ST_IDLE;
                end
                ST_UPDATE: begin
                    if (raw_up > lvl_q) begin
                        lvl_q <= raw_up;
                    end else if (raw_dn < lvl_q) begin
                        lvl_q <= raw_dn;
                    end
                    valid_q <= 1'b1;
                    acc     <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Placed after the case so an EOC during REQ still wins over REQ's clear.
            if (bus.i_eoc && state != ST_IDLE) begin
                pending <= 1'b1;
            end
        end
    end

    assign bus.o_den     = den_q;
    assign bus.o_daddr   = DRP_TEMP_ADDR;
    assign bus.o_dwe     = 1'b0;
    assign bus.o_lvl     = lvl_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_temp_level.sv
// Directed bench for temp_level: transaction-level averaging model plus a per-cycle output monitor.
module tb_temp_level;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    temp_level_if bus ();

    temp_level #(
        .SAMPLE_LOG2 (3),
        .T_MIN_CODE  (12'h977),
        .STEP_SHIFT  (4),
        .HYST        (4),
        .TIMEOUT     (255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state: running sum of the current batch, samples in it, expected level.
    int   m_sum     = 0;
    int   m_n       = 0;
    int   m_lvl     = 0;
    bit   exp_valid = 1'b0;
    bit   exp_to    = 1'b0;
    logic [3:0] prev_lvl = 4'd0;

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic int raw_level(input int x);
        int steps;
        if (x <= 'h977) return 0;
        steps = (x - 'h977) / 16;
        return (steps > 15) ? 15 : steps;
    endfunction

    task automatic model_accept(input int code);
        int avg;
        int up;
        int dn;
        int hi;
        m_sum += code;
        m_n++;
        if (m_n == 8) begin
            avg = m_sum / 8;
            hi  = (avg + 4 > 4095) ? 4095 : avg + 4;
            up  = raw_level(avg);
            dn  = raw_level(hi);
            if (up > m_lvl)      m_lvl = up;
            else if (dn < m_lvl) m_lvl = dn;
            m_sum     = 0;
            m_n       = 0;
            exp_valid = 1'b1;
        end
    endtask

    // Per-cycle monitor: constant DRP fields, level only moves with o_valid, no stray pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            check("daddr", int'(bus.o_daddr), 0);
            check("dwe", int'(bus.o_dwe), 0);
            if (bus.o_valid) begin
                check("valid_expected", 1, int'(exp_valid));
                check("lvl_on_valid", int'(bus.o_lvl), m_lvl);
                exp_valid = 1'b0;
            end else begin
                check("lvl_hold", int'(bus.o_lvl), int'(prev_lvl));
            end
            if (bus.o_timeout) begin
                check("timeout_expected", 1, int'(exp_to));
                exp_to = 1'b0;
            end
        end
        prev_lvl = bus.o_lvl;
    end

    task automatic pulse_eoc;
        bus.i_eoc = 1'b1;
        @(negedge clk);
        bus.i_eoc = 1'b0;
    endtask

    task automatic wait_den;
        int cyc = 0;
        while (!bus.o_den && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("den_seen", int'(bus.o_den), 1);
    endtask

    task automatic give_drdy(input logic [11:0] code);
        bus.i_do   = {code, 4'h0};
        bus.i_drdy = 1'b1;
        model_accept(int'(code));
        @(negedge clk);
        bus.i_drdy = 1'b0;
    endtask

    task automatic read_sample(input logic [11:0] code);
        pulse_eoc();
        wait_den();
        @(negedge clk);
        give_drdy(code);
        repeat (4) @(negedge clk);
        check("update_done", int'(exp_valid), 0);
    endtask

    task automatic batch(input logic [11:0] code, input int n);
        for (int i = 0; i < n; i++) read_sample(code);
    endtask

    initial begin
        int cnt;
        int dens;
        int valids;

        bus.i_eoc  = 1'b0;
        bus.i_drdy = 1'b0;
        bus.i_do   = 16'h0;

        repeat (3) @(negedge clk);
        check("rst_lvl", int'(bus.o_lvl), 0);
        check("rst_den", int'(bus.o_den), 0);
        check("rst_valid", int'(bus.o_valid), 0);
        check("rst_timeout", int'(bus.o_timeout), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Floor code -> level 0
        batch(12'h977, 8);
        check("lvl_floor", int'(bus.o_lvl), 0);

        // Rise to 8, hold inside hysteresis band, then fall to 7
        batch(12'h9F7, 8);
        check("lvl_rise_8", int'(bus.o_lvl), 8);
        batch(12'h9F5, 8);
        check("lvl_hyst_hold_8", int'(bus.o_lvl), 8);
        batch(12'h9F0, 8);
        check("lvl_fall_7", int'(bus.o_lvl), 7);

        // Saturation high, then back to zero
        batch(12'hFFF, 8);
        check("lvl_sat_15", int'(bus.o_lvl), 15);
        batch(12'h000, 8);
        check("lvl_zero", int'(bus.o_lvl), 0);

        // Timeout mid-batch: the discarded read must not count toward the batch
        batch(12'hA07, 3);
        pulse_eoc();
        wait_den();
        exp_to = 1'b1;
        cnt = 0;
        while (exp_to && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_fired", int'(exp_to), 0);
        check("timeout_latency_window", int'(cnt >= 250 && cnt <= 260), 1);
        repeat (2) @(negedge clk);
        batch(12'hA07, 5);
        check("lvl_after_timeout_9", int'(bus.o_lvl), 9);

        // Two EOCs during WAIT collapse into one re-issued request
        pulse_eoc();
        wait_den();
        @(negedge clk);
        pulse_eoc();
        @(negedge clk);
        pulse_eoc();
        give_drdy(12'hA07);
        dens = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_den) begin
                dens++;
                if (dens == 1) begin
                    @(negedge clk);
                    give_drdy(12'hA07);
                end
            end
        end
        check("pending_den_count", dens, 1);
        batch(12'hA07, 6);
        check("lvl_pending_hold_9", int'(bus.o_lvl), 9);

        // Reset in WAIT with level 9; late i_drdy after release is ignored
        pulse_eoc();
        wait_den();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_wait_lvl", int'(bus.o_lvl), 0);
        check("rst_wait_den", int'(bus.o_den), 0);
        m_lvl = 0; m_sum = 0; m_n = 0; exp_valid = 1'b0; exp_to = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.i_do   = 16'hFFF0;
        bus.i_drdy = 1'b1;
        @(negedge clk);
        bus.i_drdy = 1'b0;
        dens = 0;
        valids = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_den)   dens++;
            if (bus.o_valid) valids++;
        end
        check("late_drdy_no_den", dens, 0);
        check("late_drdy_no_valid", valids, 0);

        // Sample counter restarted from zero by reset
        batch(12'h9F7, 8);
        check("lvl_after_reset_8", int'(bus.o_lvl), 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/temp_level.md
TEMP_LEVEL -- requirements
Module: temp_level

Interface
REQ-001 SHALL have parameter SAMPLE_LOG2, default 3, meaning log2 of samples averaged per update (8).
REQ-002 SHALL have parameter T_MIN_CODE, default 12'h977, meaning 12-bit XADC code mapped to level 0 (about 25 C).
REQ-003 SHALL have parameter STEP_SHIFT, default 4, meaning codes per level = 2^STEP_SHIFT (about 2 C per level).
REQ-004 SHALL have parameter HYST, default 4, meaning downward hysteresis in 12-bit codes.
REQ-005 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for i_drdy.
REQ-006 SHALL have port clk, input, 1, the single system clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_eoc, input, 1, XADC end-of-conversion pulse.
REQ-009 SHALL have port o_den, output, 1, DRP enable, one-cycle pulse.
REQ-010 SHALL have port o_daddr, output, 7, DRP address, constant 7'h00 (temperature status).
REQ-011 SHALL have port o_dwe, output, 1, DRP write enable, constant 0.
REQ-012 SHALL have port i_drdy, input, 1, DRP data ready.
REQ-013 SHALL have port i_do, input, 16, DRP read data; bits [15:4] hold the 12-bit code.
REQ-014 SHALL have port o_lvl, output, 4, registered brightness level for the downstream PWM stage.
REQ-015 SHALL have port o_valid, output, 1, one-cycle pulse when an update completes.
REQ-016 SHALL have port o_timeout, output, 1, one-cycle pulse on DRP timeout.

Function
REQ-017 SHALL run FSM states IDLE, REQ, WAIT, ACC, UPDATE.
REQ-018 IDLE SHALL go to REQ on i_eoc or a pending flag; otherwise it stays in IDLE.
REQ-019 REQ SHALL assert o_den for exactly one cycle, clear pending, clear the wait counter, then go to WAIT.
REQ-020 WAIT SHALL latch i_do[15:4] and go to ACC on i_drdy; otherwise it increments the wait counter.
REQ-021 WAIT SHALL pulse o_timeout and return to IDLE, discarding the sample without touching the accumulator, when the counter reaches TIMEOUT without i_drdy.
REQ-022 i_eoc arriving outside IDLE SHALL set a single pending flag; further i_eoc pulses while pending SHALL be dropped.
REQ-023 ACC SHALL add the sample to an accumulator of width 12+SAMPLE_LOG2 (no overflow possible) and increment a SAMPLE_LOG2-bit sample counter.
REQ-024 ACC SHALL go to UPDATE when the counter wraps to 0; otherwise it goes to IDLE.
REQ-025 In UPDATE, avg SHALL equal acc >> SAMPLE_LOG2, truncated.
REQ-026 raw(x) SHALL be 0 if x <= T_MIN_CODE; otherwise min(15, (x - T_MIN_CODE) >> STEP_SHIFT); subtraction 12-bit, saturating.
REQ-027 UPDATE SHALL set o_lvl to raw(avg) if raw(avg) > o_lvl.
REQ-028 UPDATE SHALL set o_lvl to raw(avg + HYST) if raw(avg + HYST) < o_lvl; avg + HYST SHALL saturate at 12'hFFF.
REQ-029 UPDATE SHALL otherwise hold o_lvl.
REQ-030 UPDATE SHALL pulse o_valid one cycle (also when o_lvl is unchanged), clear the accumulator, and return to IDLE.
REQ-031 o_lvl SHALL change only in the UPDATE cycle, registered, with the new value visible the cycle after UPDATE.
REQ-032 i_drdy outside WAIT SHALL be ignored.
REQ-033 i_eoc coincident with UPDATE SHALL set pending.

Reset
REQ-034 rst_n low SHALL asynchronously force state IDLE, o_lvl 0, o_valid 0, o_den 0, o_timeout 0, accumulator 0, sample counter 0, pending 0, wait counter 0.
REQ-035 Reset mid-WAIT SHALL abandon the DRP transaction, and a late i_drdy after release SHALL be ignored.
REQ-036 Release SHALL take effect on the first clk edge after rst_n rises.

Structure
REQ-037 A shared package SHALL hold the FSM state enumeration, DRP_TEMP_ADDR = 7'h00, and the code width constant 12.
REQ-038 The raw() mapping SHALL be one sub-module, temp_lvl_map (combinational, parameterised by T_MIN_CODE and STEP_SHIFT), instantiated twice (avg and avg + HYST).

Verification
REQ-039 Scenario: 8 reads of i_do = 16'h9770 -> o_valid once after the 8th, o_lvl = 0.
REQ-040 Scenario: 8 reads of code 12'h9F7 (128 above min) -> o_lvl = 8; then 8 reads of 12'h9F5 -> o_lvl stays 8; then 8 reads of 12'h9F0 -> o_lvl = 7.
REQ-041 Scenario: 8 reads of 12'hFFF -> o_lvl = 15 (saturation); then 8 reads of 12'h000 -> o_lvl = 0.
REQ-042 Scenario: withhold i_drdy 255 cycles -> o_timeout pulse, sample counter unchanged, next i_eoc reissues o_den.
REQ-043 Scenario: two i_eoc during WAIT -> exactly one extra o_den after return to IDLE.
REQ-044 Scenario: assert rst_n low during WAIT with o_lvl = 9 -> o_lvl = 0 immediately, o_den low, late i_drdy after release produces no o_valid.
